// File: rtl/imem_fetch.sv
module imem_fetch #(
  parameter int    DEPTH      = 1024,
  parameter int    DATA_WIDTH = 32,
  parameter string INIT_FILE  = "Instructions.mem",
  localparam int   AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [1:0]            resp_fault,
  input  logic                  flush,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {
    HB_EMPTY,
    HB_ONE,
    HB_TWO
  } hb_state_t;

  hb_state_t             hb_state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_valid;
  logic [1:0]            rd_fault;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] hb_data  [2];
  logic [1:0]            hb_fault [2];

  logic                  hb_nonempty;
  logic                  pend_full;
  logic                  accept;
  logic                  pop;
  logic                  pop_hb;
  logic                  push;
  logic [1:0]            req_fault;
  logic [AW-1:0]         req_idx;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_fault;

  always_comb begin
    hb_nonempty = (hb_state != HB_EMPTY);
    resp_valid  = hb_nonempty || rd_valid;
    pend_full   = (hb_state == HB_TWO) || ((hb_state == HB_ONE) && rd_valid);
    req_ready   = rst_n && !flush && (!pend_full || (resp_valid && resp_ready));
    accept      = req_valid && req_ready;
    pop         = resp_valid && resp_ready && !flush;
    pop_hb      = pop && hb_nonempty;
    // the RAM output word parks in the hold buffer unless it leaves directly this cycle
    push        = rd_valid && !(pop && !hb_nonempty);
    req_idx     = req_addr[AW+1:2];

    req_fault = 2'b00;
    if (req_addr[1:0] != 2'b00) begin
      req_fault = 2'b01;
    end else if ({1'b0, req_addr} >= ADDR_LIMIT) begin
      req_fault = 2'b10;
    end

    if (hb_nonempty) begin
      out_data  = hb_data[0];
      out_fault = hb_fault[0];
    end else begin
      out_data  = rd_data;
      out_fault = rd_fault;
    end
    resp_fault = resp_valid ? out_fault : '0;
    resp_data  = (resp_valid && (out_fault == 2'b00)) ? out_data : '0;
  end

  // read-first: the read sees the word as it was before a same-edge loader write
  always_ff @(posedge clk) begin
    if (accept && (req_fault == 2'b00)) begin
      rd_data <= mem[req_idx];
    end
    if (ld_we && rst_n) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      hb_state <= HB_EMPTY;
      rd_valid <= 1'b0;
      rd_fault <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        hb_data[i]  <= '0;
        hb_fault[i] <= '0;
      end
    end else begin
      rd_valid <= accept;
      if (accept) begin
        rd_fault <= req_fault;
      end

      if (pop_hb) begin
        hb_data[0]  <= hb_data[1];
        hb_fault[0] <= hb_fault[1];
      end
      if (push) begin
        if ((hb_state == HB_EMPTY) || ((hb_state == HB_ONE) && pop_hb)) begin
          hb_data[0]  <= rd_data;
          hb_fault[0] <= rd_fault;
        end else begin
          hb_data[1]  <= rd_data;
          hb_fault[1] <= rd_fault;
        end
      end

      case (hb_state)
        HB_EMPTY: hb_state <= push ? HB_ONE : HB_EMPTY;
        HB_ONE: begin
          if (push && !pop_hb) begin
            hb_state <= HB_TWO;
          end else if (!push && pop_hb) begin
            hb_state <= HB_EMPTY;
          end else begin
            hb_state <= HB_ONE;
          end
        end
        HB_TWO:   hb_state <= pop_hb ? HB_ONE : HB_TWO;
        default:  hb_state <= HB_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Randomized bench for imem_fetch: a queue-based reference of pending responses
// and a word-array memory model predict every handshake and response.
module tb_imem_fetch;

   localparam int DEPTH = 1024;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  fault;
   } exp_resp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic [1:0]  resp_fault;
   logic        flush;
   logic        ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   logic [31:0] mem_m [DEPTH];
   exp_resp_t   q [$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   bit          armed = 1'b0;

   imem_fetch #(
      .DEPTH(DEPTH),
      .DATA_WIDTH(32),
      .INIT_FILE("")
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr(req_addr),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_data(resp_data),
      .resp_fault(resp_fault),
      .flush(flush),
      .ld_we(ld_we),
      .ld_addr(ld_addr),
      .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check against the model, then advance the model at the edge.
   task automatic cyc(input logic rn, input logic rv, input logic [31:0] ra, input logic rr,
                      input logic fl = 1'b0, input logic we = 1'b0,
                      input logic [9:0] la = '0, input logic [31:0] ld = '0);
      exp_resp_t   e;
      logic        acc;
      logic        pop;
      logic        exp_rdy;
      int unsigned p;
      @(negedge clk);
      rst_n      = rn;
      req_valid  = rv;
      req_addr   = ra;
      resp_ready = rr;
      flush      = fl;
      ld_we      = we;
      ld_addr    = la;
      ld_data    = ld;
      #2;
      p       = q.size();
      exp_rdy = rn && !fl && (p < 2 || (p > 0 && rr));
      if (armed) begin
         check("req_ready", 32'(req_ready), 32'(exp_rdy));
         check("resp_valid", 32'(resp_valid), 32'(p > 0));
         if (p > 0) begin
            check("resp_data", resp_data, q[0].data);
            check("resp_fault", 32'(resp_fault), 32'(q[0].fault));
         end else if (!rn) begin
            check("rst_data", resp_data, 32'h0);
            check("rst_fault", 32'(resp_fault), 32'h0);
         end
      end
      acc = rv && exp_rdy;
      pop = (p > 0) && rr && rn && !fl;
      if (acc) begin
         if (ra % 4 != 0) e.fault = 2'b01;
         else if (longint'(ra) >= longint'(DEPTH) * 4) e.fault = 2'b10;
         else e.fault = 2'b00;
         e.data = (e.fault == 2'b00) ? mem_m[ra / 4] : 32'h0;
      end
      @(posedge clk);
      if (!rn || fl) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      if (we && rn) mem_m[la] = ld;
   endtask

   task automatic drain(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] w;
      int unsigned r;

      // reset; first cycle unchecked since the DUT has not yet seen an edge
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      armed = 1'b1;
      cyc(1'b0, 1'b1, 32'h0, 1'b1);
      cyc(1'b0, 1'b1, 32'h0, 1'b1);

      // preload every word through the loader
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (i == 0) w = 32'h0050_0093;
         else if (i == 1) w = 32'h00A0_0113;
         else w = $urandom;
         cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 10'(i), w);
      end

      // back-to-back fetch
      cyc(1'b1, 1'b1, 32'h0, 1'b1);
      cyc(1'b1, 1'b1, 32'h4, 1'b1);
      drain(2);

      // backpressure then release
      cyc(1'b1, 1'b1, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 32'h4, 1'b0);
      cyc(1'b1, 1'b1, 32'h8, 1'b0);
      cyc(1'b1, 1'b1, 32'h8, 1'b0);
      cyc(1'b1, 1'b1, 32'h8, 1'b1);
      drain(3);

      // fault classification
      cyc(1'b1, 1'b1, 32'h2, 1'b1);
      cyc(1'b1, 1'b1, 32'h1000, 1'b1);
      cyc(1'b1, 1'b1, 32'h1002, 1'b1);
      drain(2);

      // flush with two pending
      cyc(1'b1, 1'b1, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 32'h4, 1'b0);
      cyc(1'b1, 1'b1, 32'h8, 1'b0, 1'b1);
      drain(2);
      cyc(1'b1, 1'b1, 32'h0, 1'b1);
      drain(2);

      // read-first against a same-edge loader write
      cyc(1'b1, 1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 10'd3, 32'hDEAD_BEEF);
      cyc(1'b1, 1'b1, 32'hC, 1'b1);
      drain(2);

      // reset with two pending; loader write during reset must be ignored
      cyc(1'b1, 1'b1, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 32'h4, 1'b0);
      cyc(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 10'd0, 32'h0000_0BAD);
      cyc(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 10'd0, 32'h0000_0BAD);
      cyc(1'b1, 1'b1, 32'h0, 1'b1);
      drain(2);

      // randomized traffic
      for (int unsigned i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) a = {20'h0, 10'($urandom), 2'b00};
         else if (r <= 7) a = {20'h0, 10'($urandom), 2'($urandom_range(1, 3))};
         else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 32'h00FF_FFFF));
         else a = $urandom;
         cyc(($urandom_range(0, 99) != 0),
             ($urandom_range(0, 3) != 0),
             a,
             ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 0) ? a[11:2] : 10'($urandom),
             $urandom);
      end
      drain(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
